// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one 1R1W block RAM between NUM_PORTS requesters. The read port and
//   the write port have independent arbiters, so one read and one write can be
//   granted in the same cycle. Read data is routed back to the winning
//   requester one cycle after its grant.
//
//   Configuration macro: BRAM_ARB_RR_EN
//     defined   : round-robin arbitration. Each arbiter owns a pointer, and the
//                 search starts at that pointer and wraps upward.
//     undefined : fixed priority. The lowest-index active port wins, and no
//                 pointer registers exist.
//
//   Handshake: a request transfers in the cycle where rq_valid[i] & rq_ready[i]
//   are both 1. rq_ready is combinational from the same-cycle request. The
//   requester keeps addr/wdata/write stable until it sees rq_ready. Responses
//   have no back-pressure: rsp_valid is one-hot or zero and must be taken in
//   the cycle it is shown.
//
//   Reset (active-low, asynchronous) forces every grant, enable and response
//   to 0 while it is low, so an in-flight read response is dropped.
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_PORTS  = 2   // legal range 2..4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             rq_valid,
    input  logic [NUM_PORTS-1:0]             rq_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rq_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  rq_wdata,
    output logic [NUM_PORTS-1:0]             rq_ready,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             readEnable,
    output logic [ADDR_WIDTH-1:0]            readAddress,
    input  logic [DATA_WIDTH-1:0]            readData,
    output logic                             writeEnable,
    output logic [ADDR_WIDTH-1:0]            writeAddress,
    output logic [DATA_WIDTH-1:0]            writeData
);

    // Port index width. The pick result also carries a "found" bit on top.
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = PW + 1;

    // Returns {found, index} of the first set bit of req, scanning upward
    // from start and wrapping past NUM_PORTS-1 back to 0.
    function automatic logic [CW-1:0] find_first(input logic [NUM_PORTS-1:0] req,
                                                 input logic [PW-1:0]        start);
        logic [CW-1:0] cand;
        logic [CW-1:0] res;
        logic          found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, start} + CW'(k);
            if (cand >= CW'(NUM_PORTS)) begin
                cand = cand - CW'(NUM_PORTS);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                res   = {1'b1, cand[PW-1:0]};
            end
        end
        return res;
    endfunction

    logic [NUM_PORTS-1:0] rd_req;
    logic [NUM_PORTS-1:0] wr_req;
    logic [PW-1:0]        rd_start;
    logic [PW-1:0]        wr_start;
    logic [CW-1:0]        rd_pick;
    logic [CW-1:0]        wr_pick;
    logic                 rd_hit;
    logic                 wr_hit;
    logic [PW-1:0]        rd_win;
    logic [PW-1:0]        wr_win;
    logic [NUM_PORTS-1:0] rd_gnt;
    logic [NUM_PORTS-1:0] wr_gnt;

    logic                 rsp_pend_q;
    logic                 rsp_pend_d;
    logic [PW-1:0]        rsp_owner_q;
    logic [PW-1:0]        rsp_owner_d;
    logic                 rsp_live;

    // Each arbiter only sees requests of its own direction.
    assign rd_req = rq_valid & ~rq_write;
    assign wr_req = rq_valid &  rq_write;

`ifdef BRAM_ARB_RR_EN
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;

    assign rd_start = rd_ptr_q;
    assign wr_start = wr_ptr_q;

    // Pointer moves one past the winner on a grant and holds when idle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rd_hit) begin
            rd_ptr_d = (rd_win == LAST_PORT) ? '0 : rd_win + PW'(1);
        end
        if (wr_hit) begin
            wr_ptr_d = (wr_win == LAST_PORT) ? '0 : wr_win + PW'(1);
        end
    end

    // Round-robin pointer registers, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end
`else
    // Fixed priority: the search always starts at port 0.
    assign rd_start = '0;
    assign wr_start = '0;
`endif

    assign rd_pick = find_first(rd_req, rd_start);
    assign wr_pick = find_first(wr_req, wr_start);

    // A winner only counts while reset is released.
    assign rd_hit  = rd_pick[PW] & reset;
    assign wr_hit  = wr_pick[PW] & reset;
    assign rd_win  = rd_pick[PW-1:0];
    assign wr_win  = wr_pick[PW-1:0];

    // Turn the winners into one-hot grants and mux their fields onto the BRAM
    // ports. Everything stays 0 when there is no winner.
    always_comb begin
        rd_gnt       = '0;
        wr_gnt       = '0;
        readAddress  = '0;
        writeAddress = '0;
        writeData    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_hit && (rd_win == PW'(i))) begin
                rd_gnt[i]   = 1'b1;
                readAddress = rq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (wr_hit && (wr_win == PW'(i))) begin
                wr_gnt[i]    = 1'b1;
                writeAddress = rq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                writeData    = rq_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign readEnable  = rd_hit;
    assign writeEnable = wr_hit;
    assign rq_ready    = rd_gnt | wr_gnt;

    // Remember who was granted a read. The BRAM returns the data one cycle later.
    always_comb begin
        rsp_pend_d  = rd_hit;
        rsp_owner_d = rd_hit ? rd_win : rsp_owner_q;
    end

    // Response tracking registers, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= '0;
        end else begin
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign rsp_live = rsp_pend_q & reset;

    // Steer the registered BRAM read data to the owner of the pending read.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = rsp_live ? readData : '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rsp_valid[i] = rsp_live && (rsp_owner_q == PW'(i));
        end
    end

endmodule
